cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the CPU top. Merges the CPU instruction channel pair and data channel pair onto one memory request/response port.
- Routes each read response back to the channel that issued it, using an in-order tag FIFO.
- Arbitration gives data priority, with a counter-based anti-starvation override for instruction fetch.

Parameters:
- OUTSTANDING, 4: max reads in flight (tag FIFO depth); power of 2, ≥2.
- STARVE_LIMIT, 8: consecutive cycles an instruction request may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- PC  in  32  instruction fetch address.
- Inst_Req_Valid  in  1  instruction request valid.
- Inst_Req_Ready  out  1  instruction request accepted.
- Instruction  out  32  instruction response data.
- Inst_Valid  out  1  instruction response valid.
- Inst_Ready  in  1  CPU accepts instruction response.
- Address  in  32  data address.
- MemWrite  in  1  data write request.
- Write_data  in  32  store data.
- Write_strb  in  4  store byte enables.
- MemRead  in  1  data read request.
- Mem_Req_Ready  out  1  data request accepted.
- Read_data  out  32  load response data.
- Read_data_Valid  out  1  load response valid.
- Read_data_Ready  in  1  CPU accepts load response.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  request address.
- mem_req_wen  out  1  1 = write, 0 = read.
- mem_req_wdata  out  32  write data.
- mem_req_wstrb  out  4  write strobes (4'b0 on reads).
- mem_rsp_valid  in  1  read response valid.
- mem_rsp_data  in  32  read response data.
- mem_rsp_ready  out  1  arbiter accepts response.
- rsp_err  out  1  sticky: a response arrived with no outstanding read.
- req_cnt  out  32  count of accepted memory requests.

Behaviour:
- Reset (rst=0, async):
  - Tag FIFO empty; count=0; starve counter=0.
  - rsp_err=0; req_cnt=0.
  - All ready/valid outputs 0 while reset is asserted.
  - Reads in flight at reset are forgotten. Responses arriving afterwards hit the empty FIFO and set rsp_err.
- Request definitions:
  - d_req = MemRead|MemWrite.
  - d_rd = MemRead & ~MemWrite. MemRead and MemWrite both high is treated as a write.
  - full = (count==OUTSTANDING), using the registered count only. A pop in the same cycle does not free a slot for a push.
- Grant selection (combinational, zero latency):
  - sel_inst = Inst_Req_Valid & (~d_req | starve==STARVE_LIMIT).
  - sel_data = d_req & ~sel_inst.
  - A read candidate is blocked when full. A write is never blocked by full.
  - If the selected candidate is blocked, mem_req_valid=0 that cycle.
  - There is no fallback to the other requester.
- Memory request outputs:
  - mem_req_valid = (sel_inst|sel_data) & ~blocked.
  - Payload muxed from the selected channel. Instruction: addr=PC, wen=0, wstrb=0.
- CPU-side readies:
  - Inst_Req_Ready = sel_inst & ~full & mem_req_ready.
  - Mem_Req_Ready = sel_data & (MemWrite | ~full) & mem_req_ready.
- Tag FIFO push: on each accepted read, push tag 0 (instruction) or 1 (data).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle Inst_Req_Valid=1 and no instruction handshake occurs.
  - Clears on an instruction handshake or when Inst_Req_Valid=0.
- Response routing:
  - head = FIFO head tag.
  - Inst_Valid = mem_rsp_valid & ~empty & ~head.
  - Read_data_Valid = mem_rsp_valid & ~empty & head.
  - Instruction = Read_data = mem_rsp_data.
  - mem_rsp_ready = ~empty & (head ? Read_data_Ready : Inst_Ready).
  - Pop on mem_rsp_valid & mem_rsp_ready.
- Empty-FIFO response: mem_rsp_valid while empty gives mem_rsp_ready=0, and rsp_err is set next cycle and held until reset.
- Simultaneous push and pop when not full: count unchanged; pointers both advance.
- Pointers wrap modulo OUTSTANDING. count is log2(OUTSTANDING)+1 bits.
- req_cnt increments by 1 per mem_req handshake and wraps at 2^32.
- There is no internal buffering of requests: payload and valid pass through combinationally.

Test Plan:
- Inst read only: Inst_Req_Valid=1, PC=0x100, mem_req_ready=1 → mem_req_addr=0x100, wen=0, Inst_Req_Ready=1. Next-cycle response 0xDEADBEEF → Inst_Valid=1, Instruction=0xDEADBEEF, Read_data_Valid=0.
- Contention: inst and data read both valid every cycle, memory always ready → data wins cycles 0–7, inst forced on cycle 8 (STARVE_LIMIT=8). Responses returned in order reach the correct channels.
- Full: 4 reads accepted, no responses → 5th read gets mem_req_valid=0 and ready=0. A write (MemWrite=1, strb=4'b0011) is still accepted. One response pops, and the read is accepted the following cycle.
- Backpressure: head tag=data, Read_data_Ready=0 → mem_rsp_ready=0, FIFO unchanged. Raise ready → pop, and the next head is routed to the instruction channel.
- Spurious response with FIFO empty → mem_rsp_ready=0, rsp_err=1 next cycle and sticky. Async rst low mid-burst with 3 outstanding → count=0, req_cnt=0 immediately.
- Counter: 10 accepted requests (mixed read/write) → req_cnt=10. MemRead=MemWrite=1 → issued as write, no tag pushed.

Source files
------------

// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter_if
// Description : CPU instruction/data channels, memory port and status bundle
//               for the CPU-to-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_arbiter_if;
    // Instruction channel
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    // Data channel
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    // Memory port
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_ready;
    // Status
    logic        rsp_err;
    logic [31:0] req_cnt;

    // Arbiter side
    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ready,
        input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output Inst_Req_Ready, Instruction, Inst_Valid,
        output Mem_Req_Ready, Read_data, Read_data_Valid,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_rsp_ready, rsp_err, req_cnt
    );

    // CPU / memory environment side
    modport master (
        output PC, Inst_Req_Valid, Inst_Ready,
        output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
        input  Mem_Req_Ready, Read_data, Read_data_Valid,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_rsp_ready, rsp_err, req_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Merges CPU instruction and data channels onto one memory
//               port. Data has priority; a starvation counter forces an
//               instruction fetch through after STARVE_LIMIT lost cycles.
//               Read responses are steered back by an in-order tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire              clk,
    input  wire              rst,     // asynchronous, active-low
    cpu_mem_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(OUTSTANDING);
    localparam logic [STV_W-1:0] c_STARVE   = STV_W'(STARVE_LIMIT);

    // Tag FIFO: 0 = instruction read, 1 = data read
    logic [OUTSTANDING-1:0] r_tags;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic [STV_W-1:0]       r_starve;
    logic                   r_rsp_err;
    logic [31:0]            r_req_cnt;

    logic w_d_req, w_d_rd, w_full, w_empty, w_starved;
    logic w_sel_inst, w_sel_data, w_blocked, w_wen;
    logic w_req_valid, w_req_hs, w_inst_hs, w_push;
    logic w_head, w_rsp_ready, w_pop;

    // Grant selection and request-side handshakes; everything is held
    // inactive while reset is asserted so no handshake can leak through.
    always_comb begin
        w_d_req     = bus.MemRead | bus.MemWrite;
        w_d_rd      = bus.MemRead & ~bus.MemWrite;
        w_full      = (r_count == c_FULL_CNT);
        w_empty     = (r_count == '0);
        w_starved   = (r_starve == c_STARVE);
        w_sel_inst  = rst & bus.Inst_Req_Valid & (~w_d_req | w_starved);
        w_sel_data  = rst & w_d_req & ~w_sel_inst;
        // Selected read blocked on a full FIFO; no fallback to the loser.
        w_blocked   = w_full & (w_sel_inst | (w_sel_data & w_d_rd));
        w_wen       = w_sel_data & bus.MemWrite;
        w_req_valid = (w_sel_inst | w_sel_data) & ~w_blocked;
        w_req_hs    = w_req_valid & bus.mem_req_ready;
        w_inst_hs   = w_sel_inst & ~w_full & bus.mem_req_ready;
        w_push      = w_req_hs & ~w_wen;
        w_head      = r_tags[r_rptr];
        w_rsp_ready = rst & ~w_empty & (w_head ? bus.Read_data_Ready : bus.Inst_Ready);
        w_pop       = bus.mem_rsp_valid & w_rsp_ready;
    end

    assign bus.mem_req_valid   = w_req_valid;
    assign bus.mem_req_addr    = w_sel_inst ? bus.PC : bus.Address;
    assign bus.mem_req_wen     = w_wen;
    assign bus.mem_req_wdata   = w_wen ? bus.Write_data : 32'd0;
    assign bus.mem_req_wstrb   = w_wen ? bus.Write_strb : 4'd0;
    assign bus.Inst_Req_Ready  = w_inst_hs;
    assign bus.Mem_Req_Ready   = w_sel_data & (bus.MemWrite | ~w_full) & bus.mem_req_ready;

    assign bus.mem_rsp_ready   = w_rsp_ready;
    assign bus.Inst_Valid      = rst & bus.mem_rsp_valid & ~w_empty & ~w_head;
    assign bus.Read_data_Valid = rst & bus.mem_rsp_valid & ~w_empty & w_head;
    assign bus.Instruction     = bus.mem_rsp_data;
    assign bus.Read_data       = bus.mem_rsp_data;
    assign bus.rsp_err         = r_rsp_err;
    assign bus.req_cnt         = r_req_cnt;

    // Tag FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tags  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wptr] <= w_sel_data;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Starvation counter for pending instruction fetches, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (!bus.Inst_Req_Valid || w_inst_hs) begin
            r_starve <= '0;
        end else if (!w_starved) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // Sticky error on a response with nothing outstanding; request counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_err <= 1'b0;
            r_req_cnt <= '0;
        end else begin
            if (bus.mem_rsp_valid && w_empty) begin
                r_rsp_err <= 1'b1;
            end
            if (w_req_hs) begin
                r_req_cnt <= r_req_cnt + 32'd1;
            end
        end
    end
endmodule
`default_nettype wire
